// File: rtl/alu_scheduler.sv
// alu_scheduler: shares one 64-bit adder between two requesters, holding each result until consumed
module alu (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] sum,
  output logic        c,
  output logic        v,
  output logic        z
);
  logic [64:0] full;
  assign full = {1'b0, a} + {1'b0, b};
  assign sum  = full[63:0];
  assign c    = full[64];
  assign v    = (a[63] ~^ b[63]) & (a[63] ^ full[63]);
  assign z    = ~|full[63:0];
endmodule

module alu_scheduler #(
  parameter int PRIO_FIXED = 0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req0_i,
  input  logic [63:0] a0_i,
  input  logic [63:0] b0_i,
  output logic        ack0_o,
  input  logic        req1_i,
  input  logic [63:0] a1_i,
  input  logic [63:0] b1_i,
  output logic        ack1_o,
  output logic        rsp_valid_o,
  output logic        rsp_id_o,
  input  logic        rsp_ready_i,
  output logic [63:0] sum_o,
  output logic        cflag_o,
  output logic        vflag_o,
  output logic        zflag_o,
  output logic        busy_o
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t      state, state_n;
  logic        last_grant, grant_id, issue, id_q;
  logic [63:0] a_q, b_q, alu_sum;
  logic        alu_c, alu_v, alu_z;
  alu u_alu (.a(a_q), .b(b_q), .sum(alu_sum), .c(alu_c), .v(alu_v), .z(alu_z));
  // A new op may issue from IDLE, or from DONE in the same cycle the result is consumed
  always_comb begin
    grant_id = (PRIO_FIXED != 0) ? ~req0_i : (req0_i & req1_i) ? ~last_grant : req1_i;
    issue    = (req0_i | req1_i) & ((state == IDLE) | ((state == DONE) & rsp_ready_i));
    ack0_o   = issue & ~grant_id;
    ack1_o   = issue & grant_id;
    state_n  = issue ? EXEC : (state == EXEC) ? DONE : ((state == DONE) & rsp_ready_i) ? IDLE : state;
  end
  assign busy_o = state != IDLE;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      sum_o       <= '0;
      cflag_o     <= 1'b0;
      vflag_o     <= 1'b0;
      zflag_o     <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= 1'b0;
    end else begin
      state <= state_n;
      if (issue) begin
        a_q        <= grant_id ? a1_i : a0_i;
        b_q        <= grant_id ? b1_i : b0_i;
        id_q       <= grant_id;
        last_grant <= grant_id;
      end
      if (state == EXEC) begin
        sum_o       <= alu_sum;
        cflag_o     <= alu_c;
        vflag_o     <= alu_v;
        zflag_o     <= alu_z;
        rsp_id_o    <= id_q;
        rsp_valid_o <= 1'b1;
      end else if ((state == DONE) & rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end
    end
endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: table-driven and scoreboard checks of the shared-adder scheduler
module tb_alu_scheduler;
  logic        clk = 0, reset_i = 1;
  logic        req0 = 0, req1 = 0, rsp_ready = 1;
  logic [63:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic        ack0, ack1, rsp_valid, rsp_id, cflag, vflag, zflag, busy;
  logic [63:0] sum;
  logic        f_ack0, f_ack1, f_valid, f_id, f_c, f_v, f_z, f_busy;
  logic [63:0] f_sum;
  int          errors = 0, checks = 0;
  logic [67:0] sb[$];

  alu_scheduler #(.PRIO_FIXED(0)) dut (
    .clk_i(clk), .reset_i(reset_i), .req0_i(req0), .a0_i(a0), .b0_i(b0), .ack0_o(ack0),
    .req1_i(req1), .a1_i(a1), .b1_i(b1), .ack1_o(ack1), .rsp_valid_o(rsp_valid),
    .rsp_id_o(rsp_id), .rsp_ready_i(rsp_ready), .sum_o(sum), .cflag_o(cflag),
    .vflag_o(vflag), .zflag_o(zflag), .busy_o(busy));

  alu_scheduler #(.PRIO_FIXED(1)) dut_f (
    .clk_i(clk), .reset_i(reset_i), .req0_i(req0), .a0_i(a0), .b0_i(b0), .ack0_o(f_ack0),
    .req1_i(req1), .a1_i(a1), .b1_i(b1), .ack1_o(f_ack1), .rsp_valid_o(f_valid),
    .rsp_id_o(f_id), .rsp_ready_i(rsp_ready), .sum_o(f_sum), .cflag_o(f_c),
    .vflag_o(f_v), .zflag_o(f_z), .busy_o(f_busy));

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [63:0] a, b, s;
    logic        c, v, z;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [67:0] model(input logic id, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] f;
    logic        v;
    f = {1'b0, a} + {1'b0, b};
    v = (a[63] == b[63]) && (f[63] != a[63]);
    return {id, f[64], v, f[63:0] == 64'd0, f[63:0]};
  endfunction

  // Result scoreboard: one pop per consumed response
  always @(negedge clk)
    if (!reset_i) begin
      if (ack0 | ack1) check("one_ack", {ack0, ack1} == 2'b11, 0);
      if (rsp_valid && rsp_ready) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) check("rsp", {rsp_id, cflag, vflag, zflag, sum}, sb.pop_front());
      end
    end

  task automatic do_reset();
    reset_i = 1;
    repeat (2) @(posedge clk);
    #1 reset_i = 0;
    sb.delete();
  endtask

  task automatic run_op(input logic id, input logic [63:0] a, input logic [63:0] b,
                        input logic [67:0] exp);
    logic got = 0;
    @(posedge clk); #1;
    if (id) begin req1 = 1; a1 = a; b1 = b; end
    else begin req0 = 1; a0 = a; b0 = b; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = id ? ack1 : ack0;
    end
    check("ack_seen", got, 1);
    if (got) sb.push_back(exp);
    @(posedge clk); #1 req0 = 0; req1 = 0;
    @(negedge clk);
    check("exec_valid", rsp_valid, 0);
    check("exec_busy", busy, 1);
    @(negedge clk);
    check("done_valid", rsp_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [63:0] ra, rb;
    logic        rid, got, id, exp_id;
    int          n, cyc, last, f0, f1, hold_bad;
    tbl[0] = '{0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 0, 1, 0};
    tbl[1] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1, 0, 1};
    tbl[2] = '{0, 64'd0, 64'd0, 64'd0, 0, 0, 1};
    tbl[3] = '{1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1, 1, 1};
    tbl[4] = '{0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'h2222_2222_2222_2211, 0, 0, 0};
    tbl[5] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0};
    tbl[6] = '{0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0};
    tbl[7] = '{1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0};
    #2;
    check("reset_outs", {ack0, ack1, rsp_valid, rsp_id, sum, cflag, vflag, zflag, busy}, 0);
    do_reset();
    repeat (10) @(negedge clk);
    check("idle_outs", {ack0, ack1, rsp_valid, rsp_id, sum, cflag, vflag, zflag, busy}, 0);

    foreach (tbl[i])
      run_op(tbl[i].id, tbl[i].a, tbl[i].b,
             {tbl[i].id, tbl[i].c, tbl[i].v, tbl[i].z, tbl[i].s});
    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rid = 1'($urandom_range(0, 1));
      run_op(rid, ra, rb, model(rid, ra, rb));
    end

    // Both requesting continuously from reset: strict alternation starting with 0
    @(posedge clk); #1;
    do_reset();
    req0 = 1; a0 = 64'd10; b0 = 64'd20;
    req1 = 1; a1 = 64'd1000; b1 = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_id = 0; n = 0; cyc = 0; last = 0; f0 = 0; f1 = 0;
    while (n < 8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (f_ack0) f0++;
      if (f_ack1) f1++;
      if (ack0 | ack1) begin
        id = ack1;
        check("rr_order", id, exp_id);
        if (n > 0) check("rr_gap", cyc - last, 2);
        sb.push_back(id ? model(1, a1, b1) : model(0, a0, b0));
        last = cyc;
        exp_id = ~exp_id;
        n++;
      end
    end
    check("rr_count", n, 8);
    check("fixed_no_ack1", f1, 0);
    check("fixed_ack0", f0 > 0, 1);
    @(posedge clk); #1 req0 = 0; req1 = 0;
    repeat (4) @(negedge clk);
    check("rr_drained", sb.size(), 0);

    // Pending result held while consumer stalls, with another request waiting
    rsp_ready = 0;
    run_op(0, 64'd5, 64'd7, model(0, 64'd5, 64'd7));
    @(posedge clk); #1 req0 = 1; a0 = 64'd100; b0 = 64'd200;
    hold_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_no_ack", {ack0, ack1}, 0);
      check("stall_hold", {rsp_valid, rsp_id, cflag, vflag, zflag, sum}, {1'b1, 4'b0000, 64'd12});
    end
    @(posedge clk); #1 rsp_ready = 1;
    @(negedge clk);
    check("release_ack0", ack0, 1);
    if (ack0) sb.push_back(model(0, 64'd100, 64'd200));
    @(posedge clk); #1 req0 = 0;
    repeat (3) @(negedge clk);
    check("stall_drained", sb.size(), 0);

    // Reset while EXEC: busy falls asynchronously, no response follows
    @(posedge clk); #1 req1 = 1; a1 = 64'd3; b1 = 64'd4;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = ack1;
    end
    check("abort_ack", got, 1);
    @(posedge clk); #1 req1 = 0;
    check("abort_busy_pre", busy, 1);
    #2 reset_i = 1;
    #1;
    check("abort_async", {busy, rsp_valid}, 0);
    @(posedge clk); #1 reset_i = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid | busy) hold_bad++;
    end
    check("abort_no_rsp", hold_bad, 0);

    // Reset while DONE with an unconsumed result
    rsp_ready = 0;
    run_op(1, 64'd8, 64'd9, model(1, 64'd8, 64'd9));
    #2 reset_i = 1;
    #1;
    check("done_abort_async", {rsp_valid, busy, sum}, 0);
    sb.delete();
    @(posedge clk); #1 reset_i = 0; rsp_ready = 1;
    repeat (3) @(negedge clk);
    check("done_abort_quiet", {rsp_valid, busy}, 0);
    run_op(0, 64'hDEAD_BEEF, 64'h1111_1111, model(0, 64'hDEAD_BEEF, 64'h1111_1111));
    repeat (2) @(negedge clk);
    check("final_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
